// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the icestick UART transmit path.
// Holds the default clock/baud figures, the derived bit and frame lengths,
// the arbiter state encoding and a small one-hot to index helper.
package uart_pkg;

  localparam int CLK_HZ       = 12000000;
  localparam int BAUD         = 115200;
  // Rounded up so a reserved bit period is never shorter than the real one
  localparam int CLKS_IN_BAUD = CLK_HZ / BAUD + 1;
  // Start + 8 data + stop, plus one bit period of guard
  localparam int FRAME_CLKS   = 11 * CLKS_IN_BAUD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

  // Index of the set bit in a one-hot vector (highest set bit if several)
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    onehot_to_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) onehot_to_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request/grant bundle between the byte producers and
// the UART transmit arbiter, plus the arbiter's drive towards uart_tx.
// master = producer side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [7:0]         tx_byte;
  logic               tx_enable;

  modport master (
    output req,
    output req_data,
    input  grant,
    input  busy,
    input  tx_byte,
    input  tx_enable
  );

  modport slave (
    input  req,
    input  req_data,
    output grant,
    output busy,
    output tx_byte,
    output tx_enable
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational winner search. Returns the first set request bit
// at or above the pointer, wrapping to the lowest set bit when nothing at
// or above the pointer is requesting. A zero pointer gives fixed priority.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_sel;

  // Keep only requesters at or above the pointer
  assign w_mask  = ~((N_REQ'(1) << i_ptr) - N_REQ'(1));
  assign w_hi    = i_req & w_mask;
  // Nobody above the pointer: wrap around to the whole request vector
  assign w_sel   = (w_hi != '0) ? w_hi : i_req;
  // Isolate the lowest set bit of the chosen vector
  assign o_win   = w_sel & (~w_sel + N_REQ'(1));
  assign o_valid = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between N_REQ producers.
// A winner's byte is latched, uart_tx is started with a one-cycle pulse and
// further grants are blocked for a full frame, since uart_tx reports no
// busy/done. Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no pointer register); otherwise arbitration is round-robin.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int CLK_HZ     = uart_pkg::CLK_HZ,
  parameter int BAUD       = uart_pkg::BAUD,
  parameter int FRAME_CLKS = 11 * (CLK_HZ / BAUD + 1)
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus
);

  import uart_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_CLKS);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_tx_enable;
  logic             w_tx_enable_next;
  logic [7:0]       r_tx_byte;
  logic [7:0]       w_tx_byte_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic [PTR_W-1:0] w_ptr;
  logic [N_REQ-1:0] w_win;
  logic             w_valid;
  logic [7:0]       w_sel_byte;
  logic [7:0]       w_byte_terms [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // One-hot winner gates its byte onto an OR bus
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte_mux
    assign w_byte_terms[gi] = bus.req_data[8*gi +: 8] & {8{w_win[gi]}};
  end

  // OR-reduce the gated bytes into the selected byte
  always_comb begin
    w_sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_byte = w_sel_byte | w_byte_terms[i];
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0] r_ptr;
  logic [2:0]       w_win_idx;

  assign w_win_idx = onehot_to_idx(8'(w_win));
  assign w_ptr     = r_ptr;

  // Move the priority pointer just past each winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_ptr <= (w_win_idx == 3'(N_REQ - 1)) ? '0 : PTR_W'(w_win_idx + 3'd1);
    end
  end
`endif

  // Next state and next values of every registered output
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = '0;
    w_tx_enable_next = 1'b0;
    w_tx_byte_next   = r_tx_byte;
    w_cnt_next       = r_cnt;
    case (r_state)
      IDLE: begin
        // A request already present when WAIT ends is served right here
        if (w_valid) begin
          w_grant_next   = w_win;
          w_tx_byte_next = w_sel_byte;
          w_state_next   = LOAD;
        end
      end
      LOAD: begin
        w_state_next = START;
      end
      START: begin
        // Registered start pulse shows up in the first WAIT cycle,
        // two cycles after the grant becomes visible
        w_tx_enable_next = 1'b1;
        w_cnt_next       = '0;
        w_state_next     = WAIT;
      end
      WAIT: begin
        if (r_cnt == CNT_W'(FRAME_CLKS - 1)) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // busy tracks the state register: high in LOAD, START and WAIT
    w_busy_next = (w_state_next != IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_tx_enable <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_busy      <= w_busy_next;
      r_tx_enable <= w_tx_enable_next;
      r_tx_byte   <= w_tx_byte_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.tx_enable = r_tx_enable;
  assign bus.tx_byte   = r_tx_byte;

endmodule
